cache_refill: RTL

CACHE_REFILL -- requirements
Module: cache_refill

---
 rtl/cache_pkg.sv | 31 +++
 rtl/refill_timeout.sv | 39 +++
 rtl/cache_refill.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared definitions for the cache and its DDR2 refill path.
//               Holds the address and line widths, the offset/index/tag
//               split, the DDR2 app-interface command codes and the refill
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int ADDR_W   = 27;    // byte address width
    localparam int LINE_W   = 128;   // cache line width in bits
    localparam int OFFSET_W = 4;     // byte offset inside a 16-byte line
    localparam int INDEX_W  = 10;    // set index width
    localparam int TAG_W    = 13;    // tag width (ADDR_W - INDEX_W - OFFSET_W)

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WB_DATA = 3'd1,
        ST_WB_CMD  = 3'd2,
        ST_RD_CMD  = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_DONE    = 3'd5
    } refill_state_t;

endpackage
`default_nettype wire

// File: rtl/refill_timeout.sv
`default_nettype none
// ============================================================================
// Module      : refill_timeout
// Description : Read-wait watchdog. Counts the cycles during which i_en is
//               high and flags o_expired in the TIMEOUT_CYCLES-th such cycle.
//               The count restarts from zero whenever i_en drops.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_en          - high while the refill FSM waits for read data
//               o_expired     - high in the last allowed wait cycle
// Revision    : 1.0 - initial release
// ============================================================================
module refill_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_expired
);

    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_CNT_W-1:0] r_cnt;

    // The first wait cycle sees r_cnt == 0, so the limit is hit when the
    // count equals TIMEOUT_CYCLES-1; the FSM then leaves the wait state on
    // that edge, giving exactly TIMEOUT_CYCLES cycles of waiting.
    assign o_expired = i_en && (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_cnt <= '0;
        end else if (!o_expired) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_refill.sv
`default_nettype none
// ============================================================================
// Module      : cache_refill
// Description : Cache miss handler for a DDR2 app interface. Latches a miss,
//               optionally writes back the dirty victim line (data beat, then
//               write command), issues the read command, captures the
//               returned line and pulses refill_valid for one cycle.
// Ports       : clk, rst                - clock, synchronous active-high reset
//               miss_* / victim_*       - miss request from the cache
//               req_ready               - high while idle
//               refill_valid/addr/data  - one-cycle line delivery
//               refill_err              - read timed out (sticky until next miss)
//               app_*                   - DDR2 command / write / read channels
// Options     : CACHE_REFILL_TIMEOUT_EN - enables the read-wait watchdog;
//               without it the read wait is unbounded and refill_err is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_refill #(
    parameter int ADDR_W         = cache_pkg::ADDR_W,
    parameter int LINE_W         = cache_pkg::LINE_W,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    // cache side
    input  logic              miss_req,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic              miss_dirty,
    input  logic [ADDR_W-1:0] victim_addr,
    input  logic [LINE_W-1:0] victim_data,
    output logic              req_ready,
    output logic              refill_valid,
    output logic [ADDR_W-1:0] refill_addr,
    output logic [LINE_W-1:0] refill_data,
    output logic              refill_err,
    // DDR2 side
    output logic              app_en,
    output logic [2:0]        app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    input  logic              app_rdy,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    output logic [LINE_W-1:0] app_wdf_data,
    input  logic              app_wdf_rdy,
    input  logic [LINE_W-1:0] app_rd_data,
    input  logic              app_rd_data_valid
);

    import cache_pkg::*;

    // Clears the byte-offset bits so every DDR access is line aligned.
    localparam logic [ADDR_W-1:0] c_LINE_MASK =
        {{(ADDR_W - OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cycles
        $error("cache_refill: TIMEOUT_CYCLES must be at least 1");
    end

    refill_state_t     r_state;
    logic [ADDR_W-1:0] r_miss_addr;
    logic [ADDR_W-1:0] r_victim_addr;
    logic [LINE_W-1:0] r_victim_data;
    logic              w_timeout;
    logic              w_in_rd_wait;

    assign w_in_rd_wait = (r_state == ST_RD_WAIT);
    assign app_wdf_data = r_victim_data;

`ifdef CACHE_REFILL_TIMEOUT_EN
    logic r_err;

    refill_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_refill_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_en      (w_in_rd_wait),
        .o_expired (w_timeout)
    );

    assign refill_err = r_err;
`else
    assign w_timeout  = 1'b0;
    assign refill_err = 1'b0;
`endif

    // All outputs are registered and updated on the edge that enters a
    // state, so they are valid for the whole time the state is held and
    // cannot change while a DDR handshake is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_miss_addr   <= '0;
            r_victim_addr <= '0;
            r_victim_data <= '0;
            req_ready     <= 1'b1;
            app_en        <= 1'b0;
            app_cmd       <= CMD_WRITE;
            app_addr      <= '0;
            app_wdf_wren  <= 1'b0;
            app_wdf_end   <= 1'b0;
            refill_valid  <= 1'b0;
            refill_addr   <= '0;
            refill_data   <= '0;
`ifdef CACHE_REFILL_TIMEOUT_EN
            r_err         <= 1'b0;
`endif
        end else begin
            refill_valid <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (miss_req) begin
                        r_miss_addr   <= miss_addr & c_LINE_MASK;
                        r_victim_addr <= victim_addr & c_LINE_MASK;
                        r_victim_data <= victim_data;
                        req_ready     <= 1'b0;
`ifdef CACHE_REFILL_TIMEOUT_EN
                        r_err         <= 1'b0;
`endif
                        if (miss_dirty) begin
                            r_state      <= ST_WB_DATA;
                            app_wdf_wren <= 1'b1;
                            app_wdf_end  <= 1'b1;
                        end else begin
                            r_state  <= ST_RD_CMD;
                            app_en   <= 1'b1;
                            app_cmd  <= CMD_READ;
                            app_addr <= miss_addr & c_LINE_MASK;
                        end
                    end
                end

                // Single-beat line: the data beat is also the last beat.
                ST_WB_DATA: begin
                    if (app_wdf_rdy) begin
                        r_state      <= ST_WB_CMD;
                        app_wdf_wren <= 1'b0;
                        app_wdf_end  <= 1'b0;
                        app_en       <= 1'b1;
                        app_cmd      <= CMD_WRITE;
                        app_addr     <= r_victim_addr;
                    end
                end

                // app_en stays high straight into the read command.
                ST_WB_CMD: begin
                    if (app_rdy) begin
                        r_state  <= ST_RD_CMD;
                        app_cmd  <= CMD_READ;
                        app_addr <= r_miss_addr;
                    end
                end

                ST_RD_CMD: begin
                    if (app_rdy) begin
                        r_state <= ST_RD_WAIT;
                        app_en  <= 1'b0;
                    end
                end

                // Returned data wins over a timeout in the same cycle.
                ST_RD_WAIT: begin
                    if (app_rd_data_valid) begin
                        r_state      <= ST_DONE;
                        refill_data  <= app_rd_data;
                        refill_addr  <= r_miss_addr;
                        refill_valid <= 1'b1;
                    end else if (w_timeout) begin
                        r_state      <= ST_DONE;
                        refill_addr  <= r_miss_addr;
                        refill_valid <= 1'b1;
`ifdef CACHE_REFILL_TIMEOUT_EN
                        r_err        <= 1'b1;
`endif
                    end
                end

                ST_DONE: begin
                    r_state   <= ST_IDLE;
                    req_ready <= 1'b1;
                end

                default: begin
                    r_state   <= ST_IDLE;
                    req_ready <= 1'b1;
                    app_en    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
